vco_period_meter: RTL and testbench
===================================

// Module: vco_period_meter
// PURPOSE
//  Downstream monitor for the fixed-point VCO integrator. Consumes the signed
//  14-bit oscillator position it outputs once per clk and detects rising zero
//  crossings with hysteresis. Reports the oscillation period in clk cycles and
//  the per-period max/min/amplitude, so that frequency and amplitude can be
//  checked against the w setting.
// PARAMETERS
//  CNT_W      16      period counter width
//  HYST       64      hysteresis threshold (positive, < 8192); arm <= -HYST, fire >= +HYST
//  MAX_PERIOD 65535   cycle count that triggers timeout; must be <= 2^CNT_W-1
// PORTS
//  clk        in   1      clock; all state changes on posedge
//  reset      in   1      synchronous, active-high
//  en         in   1      measurement enable
//  x          in   14     signed two's-complement VCO position, one sample per clk
//  period     out  CNT_W  cycles between the last two rising crossings
//  peak_max   out  14     signed max of x over the measured period
//  peak_min   out  14     signed min of x over the measured period
//  amp        out  14     (peak_max - peak_min) >> 1, unsigned
//  meas_valid out  1      1-cycle pulse: period/peak/amp updated this cycle
//  timeout    out  1      1-cycle pulse: MAX_PERIOD reached, no closing crossing
//  locked     out  1      high from the first meas_valid until timeout/reset/en=0
// BEHAVIOUR
//  - Reset: state=S_INIT; cnt, period, peak_max, peak_min, amp = 0; all pulse outputs = 0; locked = 0.
//  - Comparisons are signed: lo = (x <= -HYST), hi = (x >= +HYST).
//  - FSM, evaluated on each posedge while en=1:
//    S_INIT  : lo -> S_ARMED.
//    S_ARMED : hi -> opening crossing: cnt<=1, run_max<=x, run_min<=x; -> S_RUN_HI.
//    S_RUN_HI: cnt<=cnt+1, track run_max/run_min with x; lo -> S_RUN_LO.
//    S_RUN_LO: no hi: as S_RUN_HI (count+track), stay.
//              hi   : closing crossing: period<=cnt, peak_max<=run_max,
//                     peak_min<=run_min, amp<=(run_max-run_min)>>1,
//                     meas_valid=1, locked<=1; then reopen: cnt<=1,
//                     run_max<=run_min<=x; -> S_RUN_HI.
//  - Period: opening crossing sampled at edge t0, closing at edge t0+P gives period=P.
//    The peaks cover samples t0..t0+P-1; the closing sample seeds the next run.
//  - Latency: outputs and meas_valid are registered and valid in the cycle after
//    the edge that sampled the closing crossing.
//  - amp arithmetic: 15-bit signed subtraction, then an arithmetic right shift by 1.
//    The result is always within 0..8191, so no overflow.
//  - Timeout: in S_RUN_HI/S_RUN_LO, if cnt == MAX_PERIOD and the edge is not a
//    closing crossing: timeout=1, locked<=0, cnt<=0, -> S_INIT.
//    A closing crossing on the same edge wins, and no timeout is raised.
//  - cnt never wraps. Timeout fires before cnt can exceed MAX_PERIOD.
//  - No counting in S_INIT or S_ARMED, so timeout can never fire there.
//  - en=0: state<=S_INIT, cnt<=0, locked<=0, no pulses.
//    period/peak/amp hold their last values. Re-enabling restarts from S_INIT.
//  - reset mid-run: full reset on that edge and the run is discarded.
//    No meas_valid or timeout is raised on the reset edge.
//  - x exactly at +/-HYST counts as crossed (inclusive thresholds).
// TESTING
//  1. Square wave x=+1000 x50 / -1000 x50 cycles, starting low ->
//     first meas_valid after the 2nd rising edge; period=100, peak_max=1000,
//     peak_min=-1000, amp=1000, locked=1; repeats every 100 cycles.
//  2. x toggling +30/-30 (inside HYST=64) -> no meas_valid, no timeout,
//     locked=0, FSM in S_INIT.
//  3. MAX_PERIOD=200, lock on a square wave with period 100, then hold x=+1000 ->
//     timeout pulse at cnt=200, locked=0; period holds 100.
//  4. Extremes: square wave between 8191 and -8192 -> amp=8191, peak_max=8191,
//     peak_min=-8192.
//  5. reset asserted for 1 cycle mid S_RUN_LO, then en=0 during a later run ->
//     all outputs 0 after reset. With en=0, locked drops and period holds;
//     on re-enable the first meas_valid needs two fresh rising crossings.
//  6. Connect the real VCO (w constant, x reset 6471) -> period is stable to
//     +/-1 cycle across 10 meas_valid pulses, and amp is within 2% of 6471.

Source files
------------

// File: rtl/vco_period_meter.sv
// Period and peak monitor for the VCO integrator output: detects rising zero
// crossings with hysteresis and reports period, per-period extremes and amplitude.
`timescale 1ns/1ps
module vco_period_meter #(
    parameter int CNT_W      = 16,
    parameter int HYST       = 64,
    parameter int MAX_PERIOD = 65535
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic signed [13:0]      x,
    output logic        [CNT_W-1:0] period,
    output logic signed [13:0]      peak_max,
    output logic signed [13:0]      peak_min,
    output logic        [13:0]      amp,
    output logic                    meas_valid,
    output logic                    timeout,
    output logic                    locked
);

    typedef enum logic [1:0] {S_INIT, S_ARMED, S_RUN_HI, S_RUN_LO} state_t;

    localparam logic signed [13:0] HYST_POS = 14'(HYST);
    localparam logic signed [13:0] HYST_NEG = 14'(-HYST);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic signed [13:0]    run_max;
    logic signed [13:0]    run_min;
    logic                  lo;
    logic                  hi;

    function automatic logic signed [13:0] smax(input logic signed [13:0] a,
                                                input logic signed [13:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [13:0] smin(input logic signed [13:0] a,
                                                input logic signed [13:0] b);
        return (a < b) ? a : b;
    endfunction

    // Span fits in 15 bits; since max >= min the halved result is 0..8191.
    function automatic logic [13:0] half_span(input logic signed [13:0] top,
                                              input logic signed [13:0] bot);
        logic signed [14:0] diff;
        diff = {top[13], top} - {bot[13], bot};
        return 14'(diff >>> 1);
    endfunction

    assign lo = (x <= HYST_NEG);
    assign hi = (x >= HYST_POS);

    always_ff @(posedge clk) begin
        meas_valid <= 1'b0;
        timeout    <= 1'b0;
        if (reset) begin
            state    <= S_INIT;
            cnt      <= '0;
            period   <= '0;
            peak_max <= '0;
            peak_min <= '0;
            amp      <= '0;
            locked   <= 1'b0;
        end else if (!en) begin
            state  <= S_INIT;
            cnt    <= '0;
            locked <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (lo) state <= S_ARMED;
                end
                S_ARMED: begin
                    if (hi) begin
                        cnt     <= CNT_ONE;
                        run_max <= x;
                        run_min <= x;
                        state   <= S_RUN_HI;
                    end
                end
                S_RUN_HI, S_RUN_LO: begin
                    // A closing crossing takes priority over the timeout check.
                    if (state == S_RUN_LO && hi) begin
                        period     <= cnt;
                        peak_max   <= run_max;
                        peak_min   <= run_min;
                        amp        <= half_span(run_max, run_min);
                        meas_valid <= 1'b1;
                        locked     <= 1'b1;
                        cnt        <= CNT_ONE;
                        run_max    <= x;
                        run_min    <= x;
                        state      <= S_RUN_HI;
                    end else if (cnt == CNT_MAX) begin
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                        cnt     <= '0;
                        state   <= S_INIT;
                    end else begin
                        cnt     <= cnt + CNT_ONE;
                        run_max <= smax(run_max, x);
                        run_min <= smin(run_min, x);
                        if (lo) state <= S_RUN_LO;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_vco_period_meter.sv
// Bench for vco_period_meter: event-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized waveforms.
`timescale 1ns/1ps
module tb_vco_period_meter;

    localparam int CNT_W = 16;
    localparam int HYST  = 64;
    localparam int MAXP  = 200;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    en;
    logic signed [13:0]      x;
    logic        [CNT_W-1:0] period;
    logic signed [13:0]      peak_max;
    logic signed [13:0]      peak_min;
    logic        [13:0]      amp;
    logic                    meas_valid;
    logic                    timeout;
    logic                    locked;

    int errors = 0;
    int checks = 0;

    vco_period_meter #(.CNT_W(CNT_W), .HYST(HYST), .MAX_PERIOD(MAXP)) dut (
        .clk(clk), .reset(reset), .en(en), .x(x),
        .period(period), .peak_max(peak_max), .peak_min(peak_min), .amp(amp),
        .meas_valid(meas_valid), .timeout(timeout), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: tracks when the current period opened and keeps every
    // sample of it; a measurement is the elapsed edge count and the extremes.
    typedef enum {M_IDLE, M_ARMED, M_RUN} mmode_t;
    mmode_t mmode = M_IDLE;
    int  cyc = 0;
    int  t0 = 0;
    bit  came_low = 0;
    int  samples[$];
    int  e_period = 0, e_max = 0, e_min = 0, e_amp = 0;
    bit  e_valid = 0, e_timeout = 0, e_locked = 0;
    bit  model_ready = 0;
    int  valid_cnt = 0, timeout_cnt = 0, last_valid_cyc = 0, last_timeout_cyc = 0;

    always @(posedge clk) begin
        int xv, mx, mn;
        bit lo, hi;
        cyc++;
        xv = x;
        lo = (xv <= -HYST);
        hi = (xv >= HYST);
        e_valid = 0;
        e_timeout = 0;
        if (reset) begin
            mmode = M_IDLE; samples.delete();
            e_period = 0; e_max = 0; e_min = 0; e_amp = 0; e_locked = 0;
            model_ready = 1;
        end else if (!en) begin
            mmode = M_IDLE; samples.delete(); e_locked = 0;
        end else begin
            case (mmode)
                M_IDLE:  if (lo) mmode = M_ARMED;
                M_ARMED: if (hi) begin
                    mmode = M_RUN; t0 = cyc; came_low = 0; samples = {xv};
                end
                M_RUN: begin
                    if (came_low && hi) begin
                        mx = samples[0]; mn = samples[0];
                        foreach (samples[k]) begin
                            if (samples[k] > mx) mx = samples[k];
                            if (samples[k] < mn) mn = samples[k];
                        end
                        e_period = cyc - t0; e_max = mx; e_min = mn; e_amp = (mx - mn) / 2;
                        e_valid = 1; e_locked = 1;
                        t0 = cyc; came_low = 0; samples = {xv};
                    end else if (cyc - t0 == MAXP) begin
                        e_timeout = 1; e_locked = 0; mmode = M_IDLE; samples.delete();
                    end else begin
                        samples.push_back(xv);
                        if (lo) came_low = 1;
                    end
                end
                default: mmode = M_IDLE;
            endcase
        end
        #1;
        if (model_ready) begin
            check("period",     int'(period),     e_period);
            check("peak_max",   int'(peak_max),   e_max);
            check("peak_min",   int'(peak_min),   e_min);
            check("amp",        int'(amp),        e_amp);
            check("meas_valid", int'(meas_valid), int'(e_valid));
            check("timeout",    int'(timeout),    int'(e_timeout));
            check("locked",     int'(locked),     int'(e_locked));
        end
        if (meas_valid === 1'b1) begin valid_cnt++;   last_valid_cyc = cyc;   end
        if (timeout === 1'b1)    begin timeout_cnt++; last_timeout_cyc = cyc; end
    end

    task automatic drive(input bit r, input bit e, input int v);
        @(negedge clk);
        reset = r; en = e; x = 14'(v);
    endtask

    task automatic square(input int hv, input int lv, input int half, input int n);
        for (int i = 0; i < n; i++) drive(0, 1, ((i / half) % 2) ? hv : lv);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    function automatic int clamp14(input int v);
        if (v > 8191) return 8191;
        if (v < -8192) return -8192;
        return v;
    endfunction

    initial begin
        int v0, t0c;
        reset = 1'b1; en = 1'b0; x = '0;
        repeat (3) @(negedge clk);
        check("rst_period", int'(period), 0);
        check("rst_amp",    int'(amp),    0);
        check("rst_locked", int'(locked), 0);

        // Square wave +/-1000, period 100, starting low
        v0 = valid_cnt;
        square(1000, -1000, 50, 400);
        settle();
        check("sq_valid_count", valid_cnt - v0, 3);
        check("sq_period",   int'(period),   100);
        check("sq_peak_max", int'(peak_max), 1000);
        check("sq_peak_min", int'(peak_min), -1000);
        check("sq_amp",      int'(amp),      1000);
        check("sq_locked",   int'(locked),   1);

        // Hold high after lock: timeout exactly MAXP cycles after the last closing
        t0c = timeout_cnt;
        for (int i = 0; i < 250; i++) drive(0, 1, 1000);
        settle();
        check("to_count",  timeout_cnt - t0c, 1);
        check("to_delay",  last_timeout_cyc - last_valid_cyc, MAXP);
        check("to_locked", int'(locked), 0);
        check("to_period_hold", int'(period), 100);

        // Toggle inside the hysteresis band: nothing happens
        v0 = valid_cnt; t0c = timeout_cnt;
        for (int i = 0; i < 200; i++) drive(0, 1, (i % 2) ? 30 : -30);
        settle();
        check("band_valid",   valid_cnt - v0, 0);
        check("band_timeout", timeout_cnt - t0c, 0);
        check("band_locked",  int'(locked), 0);

        // Inclusive thresholds: exactly +/-HYST crosses, +/-(HYST-1) does not
        v0 = valid_cnt;
        square(HYST, -HYST, 10, 60);
        settle();
        check("thr_exact_valid", valid_cnt - v0, 2);
        check("thr_exact_amp", int'(amp), HYST);
        drive(0, 0, 0);
        v0 = valid_cnt;
        square(HYST - 1, -(HYST - 1), 10, 60);
        settle();
        check("thr_below_valid", valid_cnt - v0, 0);

        // Full-scale extremes, leaving the run in its low half
        v0 = valid_cnt;
        square(8191, -8192, 20, 130);
        settle();
        check("ext_valid",    valid_cnt - v0, 2);
        check("ext_peak_max", int'(peak_max), 8191);
        check("ext_peak_min", int'(peak_min), -8192);
        check("ext_amp",      int'(amp),      8191);

        // Reset mid-run clears everything
        drive(1, 1, -8192);
        settle();
        check("mid_rst_period", int'(period),     0);
        check("mid_rst_max",    int'(peak_max),   0);
        check("mid_rst_min",    int'(peak_min),   0);
        check("mid_rst_amp",    int'(amp),        0);
        check("mid_rst_locked", int'(locked),     0);
        check("mid_rst_valid",  int'(meas_valid), 0);

        // Disable during a run, then re-enable needs two fresh crossings
        square(1000, -1000, 50, 200);
        for (int i = 0; i < 10; i++) drive(0, 0, 1000);
        settle();
        check("dis_locked", int'(locked), 0);
        check("dis_period", int'(period), 100);
        v0 = valid_cnt;
        square(1000, -1000, 50, 150);
        settle();
        check("reen_no_early_valid", valid_cnt - v0, 0);
        drive(0, 1, 1000);
        settle();
        check("reen_first_valid", valid_cnt - v0, 1);
        check("reen_period", int'(period), 100);

        // Quantized sine resembling the VCO output
        for (int i = 0; i < 1500; i++)
            drive(0, 1, $rtoi($floor(6471.0 * $sin(2.0 * 3.14159265358979 * i / 137.0) + 0.5)));
        settle();
        check("sine_period_lo", int'(int'(period) >= 136), 1);
        check("sine_period_hi", int'(int'(period) <= 138), 1);
        check("sine_amp_lo", int'(int'(amp) >= 6342), 1);
        check("sine_amp_hi", int'(int'(amp) <= 6600), 1);

        // Randomized waveforms with occasional reset/disable, model-checked
        for (int seg = 0; seg < 60; seg++) begin
            int r, hv, lv, hh, hl, reps;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                drive(1, 1, 0);
            end else if (r == 1) begin
                for (int i = 0; i < int'($urandom_range(1, 5)); i++) drive(0, 0, 0);
            end else begin
                hv = int'($urandom_range(HYST - 3, 8191));
                lv = -int'($urandom_range(HYST - 3, 8192));
                hh = int'($urandom_range(1, 130));
                hl = int'($urandom_range(1, 130));
                reps = int'($urandom_range(1, 3));
                for (int p = 0; p < reps; p++) begin
                    for (int i = 0; i < hl; i++)
                        drive(0, 1, clamp14(lv + int'($urandom_range(0, 20)) - 10));
                    for (int i = 0; i < hh; i++)
                        drive(0, 1, clamp14(hv + int'($urandom_range(0, 20)) - 10));
                end
            end
        end
        settle();
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
